// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one pipelined signed multiplier among
// NREQ requesters and returns each product tagged with the owning requester ID.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [NREQ*W-1:0]   REQ_A,
  input  logic [NREQ*W-1:0]   REQ_B,
  output logic [NREQ-1:0]     REQ_READY,
  output logic [W-1:0]        M_A,
  output logic [W-1:0]        M_B,
  input  logic [2*W-1:0]      M_P,
  output logic                RES_VALID,
  output logic [IDW-1:0]      RES_ID,
  output logic [2*W-1:0]      RES_P,
  output logic                BUSY
);

  // Requester index reached by stepping 'off' places upward from 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [W-1:0]            m_a_q, m_a_d;
  logic [W-1:0]            m_b_q, m_b_d;
  logic [LAT:0]            tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic                    res_valid_q, res_valid_d;
  logic [IDW-1:0]          res_id_q, res_id_d;
  logic [2*W-1:0]          res_p_q, res_p_d;
  logic                    busy_q, busy_d;

  logic                    gnt_vld_s;
  logic [IDW-1:0]          gnt_id_s;
  logic [NREQ-1:0]         gnt_s;

  // Grant search: first valid requester at or above the pointer, wrapping; silent in reset.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld_s && RSTN && REQ_VALID[rr_idx(ptr_q, k)]) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = rr_idx(ptr_q, k);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s) begin
      gnt_s = NREQ'(1) << gnt_id_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign REQ_READY = gnt_s;

  // Next state: pointer, operand issue, tag shift, result capture and busy flag.
  always_comb begin
    ptr_d       = ptr_q;
    m_a_d       = '0;
    m_b_d       = '0;
    res_valid_d = tag_vld_q[LAT];
    res_id_d    = res_id_q;
    res_p_d     = res_p_q;

    if (gnt_vld_s) begin
      ptr_d = (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);
      m_a_d = REQ_A[gnt_id_s*W +: W];
      m_b_d = REQ_B[gnt_id_s*W +: W];
    end else begin
      ptr_d = ptr_q;
    end

    // Stage 0 is the issue edge; stage LAT lines up with the product on M_P.
    tag_vld_d    = {tag_vld_q[LAT-1:0], gnt_vld_s};
    tag_id_d[0]  = gnt_id_s;
    for (int s = 1; s <= LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end

    if (tag_vld_q[LAT]) begin
      res_id_d = tag_id_q[LAT];
      res_p_d  = M_P;
    end else begin
      res_id_d = res_id_q;
      res_p_d  = res_p_q;
    end

    busy_d = |tag_vld_d;
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q       <= '0;
      m_a_q       <= '0;
      m_b_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_p_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      m_a_q       <= m_a_d;
      m_b_q       <= m_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_p_q     <= res_p_d;
      busy_q      <= busy_d;
    end
  end

  assign M_A       = m_a_q;
  assign M_B       = m_b_q;
  assign RES_VALID = res_valid_q;
  assign RES_ID    = res_id_q;
  assign RES_P     = res_p_q;
  assign BUSY      = busy_q;

endmodule
